mc_core_param: RTL

- Parametrised multicycle MIPS-subset core. Successor to the fixed 32-bit multicycle datapath/control pair.
- Integrates control FSM, 32-entry register file, IR, A/B/ALUOut/MDR registers and PC in one block.
- Generalised data and address widths.
- Unlike its predecessor, it adds an external memory port with a wait-state (ready) handshake, halt on illegal opcode, and debug outputs.

---
 rtl/mc_core_param.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_core_param.sv
// Parametrised multicycle MIPS-subset core: control FSM, register file and datapath with a waited memory port.
// Optional overflow trap enabled by defining MC_CORE_OVF_TRAP_EN.
module mc_core_param #(
  parameter int unsigned    DW       = 32,
  parameter int unsigned    AW       = 32,
  parameter logic [AW-1:0]  RESET_PC = '0
`ifdef MC_CORE_OVF_TRAP_EN
  , parameter logic [AW-1:0] EXC_VECTOR = AW'('h80)
`endif
) (
  input  logic          clock,
  input  logic          res,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [AW-1:0] PCOut,
  output logic [3:0]    StateOut,
  output logic          halted
);

  typedef enum logic [3:0] {
    FETCH  = 4'h0,
    DECODE = 4'h1,
    EXEC   = 4'h2,
    ALU_WB = 4'h3,
    MEM_RD = 4'h4,
    MEM_WB = 4'h5,
    MEM_WR = 4'h6,
    BRANCH = 4'h7,
    JUMP   = 4'h8,
    HALT   = 4'h9,
    EXC    = 4'hA,
    RST    = 4'hF
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  stateT         state;
  stateT         decNext;
  logic [AW-1:0] pc;
  logic [31:0]   ir;
  logic [DW-1:0] a, b, aluOut, mdr;
  logic [DW-1:0] rf [32];

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, wbIdx;
  logic [DW-1:0] immExt, opB, sum, diff, aluRes, branchTarget;
  logic [AW-1:0] pcPlus4, jumpTarget;
  logic [27:0]   jumpLow;
  logic          isR, takeBranch, ovf;

  assign opcode       = ir[31:26];
  assign funct        = ir[5:0];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign isR          = (opcode == OP_RTYPE);
  assign wbIdx        = isR ? rd : rt;
  assign immExt       = {{(DW-16){ir[15]}}, ir[15:0]};
  assign pcPlus4      = pc + AW'(4);
  assign branchTarget = DW'(pc) + (immExt << 2);
  assign takeBranch   = ((opcode == OP_BEQ) && (a == b)) || ((opcode == OP_BNE) && (a != b));
  assign jumpLow      = {ir[25:0], 2'b00};

  // pc already holds PC+4 here, so its upper field is the delay-slot region.
  generate
    if (AW > 28) begin : gJumpHi
      assign jumpTarget = {pc[AW-1:28], jumpLow};
    end else begin : gJumpLo
      assign jumpTarget = jumpLow[AW-1:0];
    end
  endgenerate

  always_comb begin
    decNext = HALT;
    case (opcode)
      OP_RTYPE: if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) decNext = EXEC;
      OP_ADDI, OP_LW, OP_SW: decNext = EXEC;
      OP_BEQ, OP_BNE: decNext = BRANCH;
      OP_J: decNext = JUMP;
      default: decNext = HALT;
    endcase
  end

  always_comb begin
    opB    = isR ? b : immExt;
    sum    = a + opB;
    diff   = a - b;
    aluRes = sum;
    if (isR) begin
      case (funct)
        FN_SUB:  aluRes = diff;
        FN_AND:  aluRes = a & b;
        FN_OR:   aluRes = a | b;
        FN_SLT:  aluRes = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
        default: aluRes = sum;
      endcase
    end
    ovf = 1'b0;
`ifdef MC_CORE_OVF_TRAP_EN
    if ((opcode == OP_ADDI) || (isR && (funct == FN_ADD)))
      ovf = (a[DW-1] == opB[DW-1]) && (sum[DW-1] != a[DW-1]);
    else if (isR && (funct == FN_SUB))
      ovf = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
`endif
  end

  always_comb begin
    mem_rd    = (state == FETCH) || (state == MEM_RD);
    mem_wr    = (state == MEM_WR);
    mem_wdata = (state == MEM_WR) ? b : '0;
    case (state)
      FETCH:          mem_addr = pc;
      MEM_RD, MEM_WR: mem_addr = AW'(aluOut);
      default:        mem_addr = '0;
    endcase
  end

  assign PCOut    = pc;
  assign StateOut = state;
  assign halted   = (state == HALT);

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      state  <= RST;
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluOut <= '0;
      mdr    <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        RST: state <= FETCH;
        FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata[31:0];
            pc    <= pcPlus4;
            state <= DECODE;
          end
        end
        DECODE: begin
          a      <= rf[rs];
          b      <= rf[rt];
          aluOut <= branchTarget;
          state  <= decNext;
        end
        EXEC: begin
          aluOut <= aluRes;
          if (opcode == OP_LW)      state <= MEM_RD;
          else if (opcode == OP_SW) state <= MEM_WR;
          else if (ovf)             state <= EXC;
          else                      state <= ALU_WB;
        end
        ALU_WB: begin
          if (wbIdx != 5'd0) rf[wbIdx] <= aluOut;
          state <= FETCH;
        end
        MEM_RD: begin
          if (mem_ready) begin
            mdr   <= mem_rdata;
            state <= MEM_WB;
          end
        end
        MEM_WB: begin
          if (rt != 5'd0) rf[rt] <= mdr;
          state <= FETCH;
        end
        MEM_WR: if (mem_ready) state <= FETCH;
        BRANCH: begin
          if (takeBranch) pc <= AW'(aluOut);
          state <= FETCH;
        end
        JUMP: begin
          pc    <= jumpTarget;
          state <= FETCH;
        end
        HALT: state <= HALT;
`ifdef MC_CORE_OVF_TRAP_EN
        EXC: begin
          pc    <= EXC_VECTOR;
          state <= FETCH;
        end
`endif
        default: state <= HALT;
      endcase
    end
  end

endmodule
